// File: rtl/led_scan_sequencer.sv
// Column-scan controller for led_array_driver: steps the active column with
// blanking gaps and double-buffers the cell grid so frames only swap between scans.
module led_scan_sequencer #(
  parameter int N            = 8,
  parameter int DRIVE_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N*N-1:0]         cells_in,
  input  logic                   cells_valid,
  output logic                   cells_ready,
  output logic                   ena,
  output logic [$clog2(N):0]     x,
  output logic [N*N-1:0]         cells,
  output logic                   frame_done
);

  localparam int XW      = $clog2(N) + 1;
  localparam int MAX_CNT = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CW      = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;
  localparam int BLANK_LAST_I = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int DRIVE_LAST_I = (DRIVE_CYCLES > 0) ? DRIVE_CYCLES - 1 : 0;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_LAST_I);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_LAST_I);
  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);
  localparam logic          NO_BLANK   = (BLANK_CYCLES == 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  if (N < 1 || N > 8) begin : g_bad_n
    $error("led_scan_sequencer: N must be in 1..8");
  end
  if (DRIVE_CYCLES < 1) begin : g_bad_drive
    $error("led_scan_sequencer: DRIVE_CYCLES must be >= 1");
  end

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [N*N-1:0] pending;
  logic           boundary;
  logic           accept;

  // A swap is safe while idle or on the last drive cycle of the last column.
  assign boundary = (state == IDLE) ||
                    (enable && state == DRIVE && cnt == DRIVE_LAST && x == X_LAST);
  assign accept   = cells_valid && cells_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      x          <= '0;
      ena        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        x     <= '0;
        ena   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            x     <= '0;
            state <= NO_BLANK ? DRIVE : BLANK;
            ena   <= NO_BLANK;
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= DRIVE;
              cnt   <= '0;
              ena   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DRIVE: begin
            if (cnt == DRIVE_LAST) begin
              cnt   <= '0;
              state <= NO_BLANK ? DRIVE : BLANK;
              ena   <= NO_BLANK;
              if (x == X_LAST) begin
                x          <= '0;
                frame_done <= 1'b1;
              end else begin
                x <= x + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            x     <= '0;
            ena   <= 1'b0;
          end
        endcase
      end
    end
  end

  // cells_ready doubles as the inverted pending-full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells       <= '0;
      cells_ready <= 1'b1;
    end else if (boundary && !cells_ready) begin
      cells       <= pending;
      cells_ready <= 1'b1;
    end else if (accept) begin
      cells_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pending <= cells_in;
  end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer: scan timing, frame double-buffering,
// enable control, async reset, and a no-blanking build.
module tb_led_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [63:0] cells_in;
  logic        cells_valid;
  logic        cells_ready;
  logic        ena;
  logic [3:0]  x;
  logic [63:0] cells;
  logic        frame_done;

  logic        enable0;
  logic [63:0] cells_in0;
  logic        cells_valid0;
  logic        cells_ready0;
  logic        ena0;
  logic [3:0]  x0;
  logic [63:0] cells0;
  logic        frame_done0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  led_scan_sequencer #(.N(8), .DRIVE_CYCLES(4), .BLANK_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cells_in(cells_in),
    .cells_valid(cells_valid), .cells_ready(cells_ready), .ena(ena), .x(x),
    .cells(cells), .frame_done(frame_done)
  );

  led_scan_sequencer #(.N(8), .DRIVE_CYCLES(4), .BLANK_CYCLES(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .enable(enable0), .cells_in(cells_in0),
    .cells_valid(cells_valid0), .cells_ready(cells_ready0), .ena(ena0), .x(x0),
    .cells(cells0), .frame_done(frame_done0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int low_cnt;
    rst_n        = 1'b0;
    enable       = 1'b0;
    cells_in     = '0;
    cells_valid  = 1'b0;
    enable0      = 1'b0;
    cells_in0    = '0;
    cells_valid0 = 1'b0;

    // reset state
    tick(2);
    chk("rst_ena", ena, 0);
    chk("rst_x", x, 0);
    chk("rst_cells", cells, 0);
    chk("rst_ready", cells_ready, 1);
    chk("rst_fd", frame_done, 0);
    rst_n = 1'b1;
    tick(1);

    // load while idle: pending, then displayed at the next idle cycle
    cells_in    = 64'hFF;
    cells_valid = 1'b1;
    tick(1);
    chk("idle_ready_low", cells_ready, 0);
    chk("idle_cells_old", cells, 0);
    cells_valid = 1'b0;
    tick(1);
    chk("idle_cells_ff", cells, 64'hFF);
    chk("idle_ready_back", cells_ready, 1);

    // full frame of scan timing: 5 samples per column, blank first
    enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      chk($sformatf("scan_ena_%0d", i), ena, (i % 5 == 0) ? 0 : 1);
      chk($sformatf("scan_x_%0d", i), x, i / 5);
      if (frame_done) pulses++;
    end
    chk("scan_fd_none", pulses, 0);
    tick(1);
    chk("wrap_x", x, 0);
    chk("wrap_fd", frame_done, 1);
    chk("wrap_ena", ena, 0);
    tick(1);
    chk("wrap_fd_clear", frame_done, 0);

    // mid-frame load at column 3 (now at frame position 1)
    tick(14);
    chk("mid_x3", x, 3);
    cells_in    = 64'hA5;
    cells_valid = 1'b1;
    tick(1);
    chk("mid_ready_low", cells_ready, 0);
    chk("mid_cells_hold", cells, 64'hFF);
    // second frame offered while full must be ignored
    cells_in = 64'h3C;
    tick(23);
    chk("pre_wrap_x", x, 7);
    chk("pre_wrap_cells", cells, 64'hFF);
    chk("pre_wrap_ready", cells_ready, 0);
    tick(1);
    chk("swap_cells_a5", cells, 64'hA5);
    chk("swap_x", x, 0);
    chk("swap_fd", frame_done, 1);
    chk("swap_ready", cells_ready, 1);
    tick(1);
    chk("second_accept", cells_ready, 0);
    chk("second_cells_hold", cells, 64'hA5);
    cells_valid = 1'b0;
    tick(38);
    chk("second_pre_wrap", cells, 64'hA5);
    tick(1);
    chk("second_swap", cells, 64'h3C);
    chk("second_fd", frame_done, 1);

    // disable at column 5 during drive
    tick(27);
    chk("dis_x5", x, 5);
    chk("dis_ena1", ena, 1);
    enable = 1'b0;
    tick(1);
    chk("dis_ena0", ena, 0);
    chk("dis_x0", x, 0);
    chk("dis_fd", frame_done, 0);
    tick(3);
    chk("dis_hold_ena", ena, 0);
    chk("dis_keep_cells", cells, 64'h3C);
    enable = 1'b1;
    tick(1);
    chk("reen_blank", ena, 0);
    chk("reen_x", x, 0);
    tick(1);
    chk("reen_drive", ena, 1);

    // pending frame in flight, then async reset mid-drive
    cells_in    = 64'h77;
    cells_valid = 1'b1;
    tick(1);
    chk("inflight_ready", cells_ready, 0);
    cells_valid = 1'b0;
    chk("pre_rst_ena", ena, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ena", ena, 0);
    chk("arst_x", x, 0);
    chk("arst_cells", cells, 0);
    chk("arst_ready", cells_ready, 1);
    enable = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("arst_discard", cells, 0);
    chk("arst_discard_ready", cells_ready, 1);

    // no-blanking build: ena stays high throughout the scan
    enable0 = 1'b1;
    pulses  = 0;
    low_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (!ena0) low_cnt++;
      if (frame_done0) pulses++;
      if (i == 5)  chk("nb_x_i5", x0, 1);
      if (i == 31) chk("nb_x_i31", x0, 7);
      if (i == 32) chk("nb_wrap_fd", frame_done0, 1);
    end
    chk("nb_ena_never_low", low_cnt, 0);
    chk("nb_fd_pulses", pulses, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
